// File: rtl/srff_arb_pkg.sv
// Shared types and the SR/T command conversion for the flip-flop bank arbiter.
package srff_arb_pkg;

   typedef enum logic [1:0] {
      CMD_HOLD   = 2'b00,
      CMD_SET    = 2'b01,
      CMD_RESET  = 2'b10,
      CMD_TOGGLE = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_ACK   = 2'b10
   } state_e;

   // The T input that moves a toggle cell from q_bit to the state the command asks for.
   function automatic logic cmd_to_t(input cmd_e c, input logic q_bit);
      case (c)
         CMD_SET:    return ~q_bit;
         CMD_RESET:  return q_bit;
         CMD_TOGGLE: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/srff_bank_arbiter_tff_cell.sv
// One toggle flip-flop of the shared bank; cleared asynchronously.
module tff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= q ^ t;
   end

endmodule

// File: rtl/srff_bank_arbiter.sv
// Arbitrates SET/RESET/TOGGLE/HOLD requests onto a bank of toggle flip-flops.
// SRFF_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (requester 0 highest).
//
// state    | meaning
// ST_IDLE  | waiting for any req; winner, cmd and idx are latched on the grant edge
// ST_ISSUE | t vector driven for the latched bit; bank updates on the edge leaving this state
// ST_ACK   | ack to the latched winner, err if the latched idx was outside the bank
module srff_bank_arbiter
   import srff_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int W     = 8,
   localparam int IW    = $clog2(W),
   localparam int NW    = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [2*N_REQ-1:0]   cmd,
   input  logic [IW*N_REQ-1:0]  idx,
   output logic [N_REQ-1:0]     ack,
   output logic                 err,
   output logic                 busy,
   output logic [W-1:0]         q
);

   state_e          r_state;
   cmd_e            r_cmd;
   logic [IW-1:0]   r_idx;
   logic [NW-1:0]   r_win;

   logic [NW-1:0]   w_win;
   cmd_e            w_cmd_sel;
   logic [IW-1:0]   w_idx_sel;
   logic [W-1:0]    w_t;
   logic [W-1:0]    w_q;

`ifdef SRFF_ARB_RR_EN
   logic [NW-1:0]   r_ptr;
   logic [NW-1:0]   w_win_next;

   // Scan downward so the requester closest to the pointer is the last (winning) assignment.
   always_comb begin
      int c;
      c     = 0;
      w_win = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         c = int'(r_ptr) + k;
         if (c >= N_REQ) c = c - N_REQ;
         if (req[c]) w_win = NW'(c);
      end
   end

   assign w_win_next = (int'(w_win) == N_REQ-1) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_ptr <= '0;
      else if (r_state == ST_IDLE && (|req))  r_ptr <= w_win_next;
   end
`else
   always_comb begin
      w_win = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (req[k]) w_win = NW'(k);
      end
   end
`endif

   always_comb begin
      w_cmd_sel = CMD_HOLD;
      w_idx_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_win == NW'(k)) begin
            w_cmd_sel = cmd_e'(cmd[2*k +: 2]);
            w_idx_sel = idx[IW*k +: IW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cmd   <= CMD_HOLD;
         r_idx   <= '0;
         r_win   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_cmd   <= w_cmd_sel;
                  r_idx   <= w_idx_sel;
                  r_win   <= w_win;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_ACK;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // An out-of-range idx matches no cell, so the whole t vector stays 0.
   always_comb begin
      w_t = '0;
      if (r_state == ST_ISSUE) begin
         for (int b = 0; b < W; b++) begin
            if (r_idx == IW'(b)) w_t[b] = cmd_to_t(r_cmd, w_q[b]);
         end
      end
   end

   for (genvar b = 0; b < W; b++) begin : g_bank
      tff_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .t     (w_t[b]),
         .q     (w_q[b])
      );
   end

   always_comb begin
      ack = '0;
      if (r_state == ST_ACK) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (r_win == NW'(k)) ack[k] = 1'b1;
         end
      end
   end

   assign err  = (r_state == ST_ACK) && ({1'b0, r_idx} >= (IW+1)'(W));
   assign busy = (r_state != ST_IDLE);
   assign q    = w_q;

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Self-checking bench: W=8 main instance plus a W=6 instance for out-of-range indices.
module tb_srff_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  cmd;
   logic [11:0] idx;
   logic [3:0]  ack;
   logic        err, busy;
   logic [7:0]  q;

   logic [3:0]  req6;
   logic [7:0]  cmd6;
   logic [11:0] idx6;
   logic [3:0]  ack6;
   logic        err6, busy6;
   logic [5:0]  q6;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_q;
   int         m_ptr;

   always #5 clk = ~clk;

   srff_bank_arbiter #(.N_REQ(4), .W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .idx(idx),
      .ack(ack), .err(err), .busy(busy), .q(q)
   );

   srff_bank_arbiter #(.N_REQ(4), .W(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .req(req6), .cmd(cmd6), .idx(idx6),
      .ack(ack6), .err(err6), .busy(busy6), .q(q6)
   );

   function automatic int pick(input logic [3:0] rq);
      for (int k = 0; k < 4; k++) begin
`ifdef SRFF_ARB_RR_EN
         if (rq[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
         if (rq[k]) return k;
`endif
      end
      return -1;
   endfunction

   task automatic model_apply(input int w, input logic [1:0] c, input int i);
      case (c)
         2'b01: m_q[i] = 1'b1;
         2'b10: m_q[i] = 1'b0;
         2'b11: m_q[i] = ~m_q[i];
         default: ;
      endcase
      m_ptr = (w + 1) % 4;
   endtask

   // One full request: drive, drop req after the grant edge, check ISSUE, ACK and return to IDLE.
   task automatic run_cmd(input logic [3:0] rq, input logic [7:0] cm, input logic [11:0] ix,
                          input string nm);
      int w;
      logic [7:0] q_old;
      logic [3:0] exp_ack;
      @(negedge clk);
      req = rq; cmd = cm; idx = ix;
      w = pick(rq);
      q_old = m_q;
      @(negedge clk);
      req = '0;
      checks++;
      if (busy !== 1'b1 || ack !== 4'b0 || q !== q_old) begin
         errors++;
         $display("FAIL %s issue: busy=%b ack=%b q=%h, expected busy=1 ack=0000 q=%h",
                  nm, busy, ack, q, q_old);
      end
      model_apply(w, cm[2*w +: 2], int'(ix[3*w +: 3]));
      exp_ack = 4'b0001 << w;
      @(negedge clk);
      checks++;
      if (ack !== exp_ack || err !== 1'b0 || q !== m_q || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s ack: ack=%b err=%b q=%h busy=%b, expected ack=%b err=0 q=%h busy=1",
                  nm, ack, err, q, busy, exp_ack, m_q);
      end
      @(negedge clk);
      checks++;
      if (ack !== 4'b0 || busy !== 1'b0 || q !== m_q) begin
         errors++;
         $display("FAIL %s idle: ack=%b busy=%b q=%h, expected ack=0000 busy=0 q=%h",
                  nm, ack, busy, q, m_q);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '0; cmd = '0; idx = '0;
      req6 = '0; cmd6 = '0; idx6 = '0;
      m_q = '0; m_ptr = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (q !== 8'h00 || ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0 || q6 !== 6'h00) begin
         errors++;
         $display("FAIL reset: q=%h ack=%b err=%b busy=%b q6=%h, expected all zero",
                  q, ack, err, busy, q6);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0 || q !== 8'h00) begin
         errors++;
         $display("FAIL reset_release: busy=%b ack=%b q=%h, expected idle", busy, ack, q);
      end
   endtask

   task automatic test_hold_all();
      int         cyc[$];
      logic [3:0] val[$];
      int         w;
      @(negedge clk);
      req = 4'b1111; cmd = 8'h00; idx = 12'($urandom);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (ack !== 4'b0) begin
            cyc.push_back(k);
            val.push_back(ack);
         end
         if (q !== m_q) begin
            checks++; errors++;
            $display("FAIL hold_all_q: q=%h, expected %h", q, m_q);
         end
      end
      req = '0;
      checks++;
      if (cyc.size() != 5) begin
         errors++;
         $display("FAIL hold_all_count: acks=%0d, expected 5", cyc.size());
      end else begin
         for (int n = 0; n < 5; n++) begin
            w = pick(4'b1111);
            model_apply(w, 2'b00, 0);
            checks++;
            if (val[n] !== (4'b0001 << w) || cyc[n] != 1 + 3*n) begin
               errors++;
               $display("FAIL hold_all_seq%0d: ack=%b at cycle %0d, expected %b at cycle %0d",
                        n, val[n], cyc[n], 4'b0001 << w, 1 + 3*n);
            end
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_all_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_set();
      run_cmd(4'b0001, 8'b00_00_00_01, 12'(3), "set_first");
      checks++;
      if (q !== 8'h08) begin
         errors++;
         $display("FAIL set_value: q=%h, expected 08", q);
      end
      run_cmd(4'b0001, 8'b00_00_00_01, 12'(3), "set_repeat");
      checks++;
      if (q !== 8'h08) begin
         errors++;
         $display("FAIL set_repeat_value: q=%h, expected 08", q);
      end
   endtask

   task automatic test_toggle();
      run_cmd(4'b0010, 8'b00_00_11_00, 12'(5) << 3, "toggle_1");
      checks++;
      if (q[5] !== 1'b1) begin
         errors++;
         $display("FAIL toggle_1_bit: q[5]=%b, expected 1", q[5]);
      end
      run_cmd(4'b0010, 8'b00_00_11_00, 12'(5) << 3, "toggle_2");
      checks++;
      if (q[5] !== 1'b0) begin
         errors++;
         $display("FAIL toggle_2_bit: q[5]=%b, expected 0", q[5]);
      end
   endtask

   task automatic test_err();
      @(negedge clk);
      req6 = 4'b0100; cmd6 = 8'b00_01_00_00; idx6 = 12'(7) << 6;
      @(negedge clk);
      req6 = '0;
      @(negedge clk);
      checks++;
      if (ack6 !== 4'b0100 || err6 !== 1'b1 || q6 !== 6'h00) begin
         errors++;
         $display("FAIL err_oob: ack=%b err=%b q=%h, expected ack=0100 err=1 q=00", ack6, err6, q6);
      end
      @(negedge clk);
      checks++;
      if (err6 !== 1'b0 || ack6 !== 4'b0 || q6 !== 6'h00) begin
         errors++;
         $display("FAIL err_clear: ack=%b err=%b q=%h, expected 0000 0 00", ack6, err6, q6);
      end
      req6 = 4'b0100; cmd6 = 8'b00_01_00_00; idx6 = 12'(5) << 6;
      @(negedge clk);
      req6 = '0;
      @(negedge clk);
      checks++;
      if (ack6 !== 4'b0100 || err6 !== 1'b0 || q6 !== 6'h20) begin
         errors++;
         $display("FAIL err_inrange: ack=%b err=%b q=%h, expected ack=0100 err=0 q=20", ack6, err6, q6);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      run_cmd(4'b0001, 8'b00_00_00_01, 12'(3), "abort_setup");
      @(negedge clk);
      req = 4'b0001; cmd = 8'b00_00_00_10; idx = 12'(3);
      @(negedge clk);
      req = '0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (ack !== 4'b0 || q !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort: ack=%b q=%h busy=%b, expected 0000 00 0", ack, q, busy);
      end
      @(negedge clk);
      checks++;
      if (ack !== 4'b0 || q !== 8'h00) begin
         errors++;
         $display("FAIL abort_noack: ack=%b q=%h, expected 0000 00", ack, q);
      end
      rst_n = 1'b1;
      m_q = '0; m_ptr = 0;
      run_cmd(4'b0011, 8'b00_00_11_01, (12'(6) << 3) | 12'(0), "after_abort");
      checks++;
      if (q !== 8'h01) begin
         errors++;
         $display("FAIL after_abort_value: q=%h, expected 01", q);
      end
   endtask

   task automatic test_random();
      logic [3:0] rq;
      for (int n = 0; n < 24; n++) begin
         rq = 4'($urandom_range(1, 15));
         run_cmd(rq, 8'($urandom), 12'($urandom), "random");
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++)
         run_cmd(4'b0001 << n, 8'b11_11_11_11, {3'(n+4), 3'(n+4), 3'(n+4), 3'(n+4)}, "back_to_back");
   endtask

   initial begin
      test_reset();
      test_hold_all();
      test_set();
      test_toggle();
      test_err();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
